// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: reset defaults, 2-bit predictor states and
// the redirect / BTB-update bundles passed around the front end.
package riscv_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_ctr_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } redirect_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } btb_upd_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: decode hazard controls, redirect/update inputs, imem port
// and the IF/ID register outputs. master = fetch stage, slave = its neighbours.
interface instruction_fetch_if;
  logic        stall_pc;
  logic        stall_if_id;
  logic        if_id_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_plus_4_out;
  logic        valid_out;
  logic        pred_taken_out;
  logic [31:0] pred_target_out;
  logic [31:0] fetch_count;

  modport master (
    input  stall_pc, stall_if_id, if_id_flush, redirect_valid, redirect_pc,
           upd_valid, upd_pc, upd_taken, upd_target, imem_data,
    output imem_addr, pc_out, instruction_out, pc_plus_4_out, valid_out,
           pred_taken_out, pred_target_out, fetch_count
  );

  modport slave (
    output stall_pc, stall_if_id, if_id_flush, redirect_valid, redirect_pc,
           upd_valid, upd_pc, upd_taken, upd_target, imem_data,
    input  imem_addr, pc_out, instruction_out, pc_plus_4_out, valid_out,
           pred_taken_out, pred_target_out, fetch_count
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters. Lookup is combinational and reads the
// array state before any same-cycle update; updates land on the clock edge.
module branch_target_buffer
  import riscv_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_lookup_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  btb_upd_t    i_upd
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [IDX-1:0]   w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  logic             w_lk_hit, w_up_hit;
  logic             w_unused;

  assign w_lk_idx = i_lookup_pc[IDX+1:2];
  assign w_lk_tag = i_lookup_pc[31:IDX+2];
  assign w_up_idx = i_upd.pc[IDX+1:2];
  assign w_up_tag = i_upd.pc[31:IDX+2];
  assign w_unused = ^{i_lookup_pc[1:0], i_upd.pc[1:0]};

  assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit      = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign o_pred_taken  = w_lk_hit && (r_ctr[w_lk_idx] >= 2'(WT));
  assign o_pred_target = r_target[w_lk_idx];

  // Only the valid bits need reset; payload is qualified by them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_valid <= '0;
    else if (i_upd.valid && !w_up_hit && i_upd.taken)
      r_valid[w_up_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_upd.valid) begin
      if (w_up_hit) begin
        if (i_upd.taken) begin
          r_target[w_up_idx] <= i_upd.target;
          if (r_ctr[w_up_idx] != 2'(ST)) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
        end else if (r_ctr[w_up_idx] != 2'(SNT)) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
        end
      end else if (i_upd.taken) begin
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= i_upd.target;
        r_ctr[w_up_idx]    <= 2'(WT);
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional branch prediction via BTB when BTB_EN is defined.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR   = DEF_NOP_INSTR,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus_4;
  logic [31:0] w_seq_next;
  logic        w_pred_taken;
  logic [31:0] w_pred_target;
  logic        w_bubble;
  logic        w_load;
  redirect_t   w_redir;
  btb_upd_t    w_upd;

  assign w_redir     = '{valid: bus.redirect_valid, pc: align_pc(bus.redirect_pc)};
  assign w_upd       = '{valid: bus.upd_valid, pc: bus.upd_pc,
                         taken: bus.upd_taken, target: bus.upd_target};
  assign w_pc_plus_4 = r_pc + 32'd4;

`ifdef BTB_EN
  branch_target_buffer #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk          (clk),
    .rst          (rst),
    .i_lookup_pc  (r_pc),
    .o_pred_taken (w_pred_taken),
    .o_pred_target(w_pred_target),
    .i_upd        (w_upd)
  );
`else
  logic w_unused_upd;
  assign w_unused_upd  = ^{w_upd, BTB_ENTRIES[0]};
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = w_pc_plus_4;
`endif

  logic w_unused_redir_lsb;
  assign w_unused_redir_lsb = ^bus.redirect_pc[1:0];

  assign w_seq_next = w_pred_taken ? w_pred_target : w_pc_plus_4;

  always_comb begin
    w_pc_next = w_seq_next;
    if (w_redir.valid)     w_pc_next = w_redir.pc;
    else if (bus.stall_pc) w_pc_next = r_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_pc_next;
  end

  assign bus.imem_addr = r_pc;

  // A redirect squashes the wrong-path fetch even when decode is stalling.
  assign w_bubble = w_redir.valid || bus.if_id_flush;
  assign w_load   = !w_bubble && !bus.stall_if_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pc_out          <= '0;
      bus.instruction_out <= NOP_INSTR;
      bus.pc_plus_4_out   <= '0;
      bus.valid_out       <= 1'b0;
      bus.pred_taken_out  <= 1'b0;
      bus.pred_target_out <= '0;
      bus.fetch_count     <= '0;
    end else if (w_bubble) begin
      bus.pc_out          <= '0;
      bus.instruction_out <= NOP_INSTR;
      bus.pc_plus_4_out   <= '0;
      bus.valid_out       <= 1'b0;
      bus.pred_taken_out  <= 1'b0;
      bus.pred_target_out <= '0;
    end else if (w_load) begin
      bus.pc_out          <= r_pc;
      bus.instruction_out <= bus.imem_data;
      bus.pc_plus_4_out   <= w_pc_plus_4;
      bus.valid_out       <= 1'b1;
      bus.pred_taken_out  <= w_pred_taken;
      bus.pred_target_out <= w_seq_next;
      bus.fetch_count     <= bus.fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, stalls, redirect, flush, PC wrap,
// async reset mid-stall, and BTB training when BTB_EN is defined.
module tb_instruction_fetch;
  import riscv_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : {a[23:0], 8'h13};
  endfunction

  assign bus.imem_data = imem_f(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic v, input logic [31:0] cnt);
    chk({tag, ".pc"},    bus.pc_out, pc);
    chk({tag, ".instr"}, bus.instruction_out, ins);
    chk({tag, ".valid"}, {31'd0, bus.valid_out}, {31'd0, v});
    chk({tag, ".count"}, bus.fetch_count, cnt);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.stall_pc = 0; bus.stall_if_id = 0; bus.if_id_flush = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0;
    bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0; bus.upd_target = 0;

    #12;
    chk("rst.addr", bus.imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h13, 1'b0, 32'd0);
    chk("rst.pt", {31'd0, bus.pred_taken_out}, 32'd0);
    chk("rst.ptgt", bus.pred_target_out, 32'h0);
    chk("rst.pc4", bus.pc_plus_4_out, 32'h0);
    rst = 1'b0;

    step();
    chk_ifid("first", 32'h0, 32'h0050_0093, 1'b1, 32'd1);
    chk("first.addr", bus.imem_addr, 32'h4);
    chk("first.pc4", bus.pc_plus_4_out, 32'h4);
    chk("first.ptgt", bus.pred_target_out, 32'h4);

    step();
    chk_ifid("seq4", 32'h4, imem_f(32'h4), 1'b1, 32'd2);
    chk("seq4.addr", bus.imem_addr, 32'h8);

    bus.stall_pc = 1; bus.stall_if_id = 1;
    step();
    chk("stall1.addr", bus.imem_addr, 32'h8);
    chk_ifid("stall1", 32'h4, imem_f(32'h4), 1'b1, 32'd2);
    step();
    chk("stall2.addr", bus.imem_addr, 32'h8);
    chk_ifid("stall2", 32'h4, imem_f(32'h4), 1'b1, 32'd2);
    bus.stall_pc = 0; bus.stall_if_id = 0;

    step();
    chk_ifid("unstall", 32'h8, imem_f(32'h8), 1'b1, 32'd3);
    chk("unstall.addr", bus.imem_addr, 32'hC);

    // redirect beats stall_pc; low address bits dropped
    bus.stall_pc = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h41;
    step();
    chk("redir.addr", bus.imem_addr, 32'h40);
    chk_ifid("redir", 32'h0, 32'h13, 1'b0, 32'd3);
    bus.stall_pc = 0; bus.redirect_valid = 0;
    step();
    chk_ifid("redir2", 32'h40, imem_f(32'h40), 1'b1, 32'd4);
    chk("redir2.addr", bus.imem_addr, 32'h44);

    // flush beats stall_if_id
    bus.if_id_flush = 1; bus.stall_if_id = 1;
    step();
    chk_ifid("flush", 32'h0, 32'h13, 1'b0, 32'd4);
    chk("flush.addr", bus.imem_addr, 32'h48);
    bus.if_id_flush = 0; bus.stall_if_id = 0;
    step();
    chk_ifid("flush2", 32'h48, imem_f(32'h48), 1'b1, 32'd5);

    // stall_pc alone: same instruction re-latched
    bus.stall_pc = 1;
    step();
    chk("spc1.addr", bus.imem_addr, 32'h4C);
    chk_ifid("spc1", 32'h4C, imem_f(32'h4C), 1'b1, 32'd6);
    step();
    chk("spc2.addr", bus.imem_addr, 32'h4C);
    chk_ifid("spc2", 32'h4C, imem_f(32'h4C), 1'b1, 32'd7);
    bus.stall_pc = 0;

    // PC wrap
    bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap0.addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.redirect_valid = 0;
    step();
    chk("wrap.addr", bus.imem_addr, 32'h0);
    chk_ifid("wrap", 32'hFFFF_FFFC, imem_f(32'hFFFF_FFFC), 1'b1, 32'd8);
    chk("wrap.pc4", bus.pc_plus_4_out, 32'h0);
    chk("wrap.ptgt", bus.pred_target_out, 32'h0);
    step();
    chk_ifid("wrap2", 32'h0, 32'h0050_0093, 1'b1, 32'd9);

    // async reset mid-stall at PC=0x20
    bus.redirect_valid = 1; bus.redirect_pc = 32'h20;
    step();
    bus.redirect_valid = 0; bus.stall_pc = 1; bus.stall_if_id = 1;
    step();
    chk("mid.addr", bus.imem_addr, 32'h20);
    #2 rst = 1'b1;
    #1;
    chk("arst.addr", bus.imem_addr, 32'h0);
    chk_ifid("arst", 32'h0, 32'h13, 1'b0, 32'd0);
    chk("arst.pc4", bus.pc_plus_4_out, 32'h0);
    chk("arst.ptgt", bus.pred_target_out, 32'h0);
    step();
    bus.stall_pc = 0; bus.stall_if_id = 0;
    rst = 1'b0;

`ifdef BTB_EN
    // train taken at 0x10 while redirecting there
    bus.upd_valid = 1; bus.upd_pc = 32'h10; bus.upd_taken = 1; bus.upd_target = 32'h80;
    bus.redirect_valid = 1; bus.redirect_pc = 32'h10;
    step();
    bus.upd_valid = 0; bus.redirect_valid = 0;
    chk("btb.addr10", bus.imem_addr, 32'h10);
    step();
    chk("btb.pc", bus.pc_out, 32'h10);
    chk("btb.pt", {31'd0, bus.pred_taken_out}, 32'd1);
    chk("btb.ptgt", bus.pred_target_out, 32'h80);
    chk("btb.addr", bus.imem_addr, 32'h80);
    bus.upd_valid = 1; bus.upd_pc = 32'h10; bus.upd_taken = 0;
    step();
    step();
    bus.upd_valid = 0;
    bus.redirect_valid = 1; bus.redirect_pc = 32'h10;
    step();
    bus.redirect_valid = 0;
    step();
    chk("btbnt.pc", bus.pc_out, 32'h10);
    chk("btbnt.pt", {31'd0, bus.pred_taken_out}, 32'd0);
    chk("btbnt.ptgt", bus.pred_target_out, 32'h14);
    chk("btbnt.addr", bus.imem_addr, 32'h14);
`else
    step();
    chk_ifid("post", 32'h0, 32'h0050_0093, 1'b1, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
